// File: rtl/sdram_device_emu_if.sv
// SDRAM pin bus between a controller (master) and the emulated chip (slave).
// Latency: none, plain wires.
// Backpressure: none; Cke is the only stall mechanism on this bus.
interface sdram_device_emu_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 13,
  parameter int BSIZE = 2
);
  logic                 Cke;
  logic                 Cs_n;
  logic                 Ras_n;
  logic                 Cas_n;
  logic                 We_n;
  logic [BSIZE-1:0]     Ba;
  logic [ASIZE-1:0]     Sa;
  logic [DSIZE/8-1:0]   Dqm;
  logic [DSIZE-1:0]     Dq_in;
  logic [DSIZE-1:0]     Dq_out;
  logic                 Dq_oe;
  logic                 Mode_ok;
  logic                 Err;
  logic [15:0]          Ref_cnt;

  modport master (
    output Cke, Cs_n, Ras_n, Cas_n, We_n, Ba, Sa, Dqm, Dq_in,
    input  Dq_out, Dq_oe, Mode_ok, Err, Ref_cnt
  );

  modport slave (
    input  Cke, Cs_n, Ras_n, Cas_n, We_n, Ba, Sa, Dqm, Dq_in,
    output Dq_out, Dq_oe, Mode_ok, Err, Ref_cnt
  );
endinterface

// File: rtl/sdram_device_emu.sv
// SDRAM chip-side emulator: decodes pin commands, tracks banks and mode, serves bursts from on-chip RAM.
// Latency: read word k of a READ sampled at cycle T is on Dq_out at T+CL+k; Err pulses one cycle after the command.
// Backpressure: none on the pin bus; Cke=0 freezes decode, burst counters and the read pipeline.
module sdram_device_emu #(
  parameter int DSIZE  = 16,
  parameter int ASIZE  = 13,
  parameter int BSIZE  = 2,
  parameter int COLW   = 9,
  parameter int MEM_AW = 12
) (
  input  logic              Clk,
  input  logic              Rst,
  sdram_device_emu_if.slave bus
);
  localparam int NB    = 1 << BSIZE;
  localparam int NBYTE = DSIZE / 8;

  // {Cs_n,Ras_n,Cas_n,We_n}; anything with Cs_n=1 is a deselect
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_BST = 4'b0110;

  typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ} burst_e;

  burst_e              r_state, w_state_nxt;
  logic [NB-1:0]       r_open;
  logic [ASIZE-1:0]    r_row [NB];
  logic [1:0]          r_bl_log;
  logic                r_cl3;
  logic                r_mode_ok;
  logic [BSIZE-1:0]    r_bank;
  logic [ASIZE-1:0]    r_brow;
  logic [COLW-1:0]     r_col;
  logic [2:0]          r_k, w_k_nxt;
  logic                r_err;
  logic [15:0]         r_ref_cnt;
  logic                r_s0_vld, r_s1_vld;
  logic [DSIZE-1:0]    r_s0_dat, r_s1_dat;
  logic [DSIZE-1:0]    r_dq_out;
  logic                r_dq_oe;
  logic [DSIZE-1:0]    r_mem [1<<MEM_AW];

  logic [3:0]          w_cmd;
  logic [2:0]          w_bl_m1;
  logic [COLW-1:0]     w_mask;
  logic                w_last;
  logic [MEM_AW-1:0]   w_cont_addr, w_cmd_addr;
  logic                w_bank_open, w_any_open, w_lmr_ok;
  logic                w_err, w_we, w_re, w_flush, w_start;
  logic [MEM_AW-1:0]   w_waddr, w_raddr;
  logic                w_pipe_vld;
  logic [DSIZE-1:0]    w_pipe_dat;

  // RAM index is {bank,row,col} keeping only the low MEM_AW bits
  function automatic logic [MEM_AW-1:0] mem_idx(input logic [BSIZE-1:0] ba,
                                                 input logic [ASIZE-1:0] row,
                                                 input logic [COLW-1:0]  col);
    return MEM_AW'({ba, row, col});
  endfunction

  // Column of burst word k: low bits count modulo BL, wrapping inside the BL-aligned block
  function automatic logic [COLW-1:0] burst_col(input logic [COLW-1:0] c,
                                                input logic [2:0]      k,
                                                input logic [COLW-1:0] mask);
    return (c & ~mask) | ((c + COLW'(k)) & mask);
  endfunction

  assign w_cmd       = {bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n};
  assign w_bl_m1     = (3'd1 << r_bl_log) - 3'd1;
  assign w_mask      = COLW'(w_bl_m1);
  assign w_last      = (r_k == w_bl_m1);
  assign w_cont_addr = mem_idx(r_bank, r_brow, burst_col(r_col, r_k, w_mask));
  assign w_cmd_addr  = mem_idx(bus.Ba, r_row[bus.Ba], bus.Sa[COLW-1:0]);
  assign w_bank_open = r_open[bus.Ba];
  assign w_any_open  = |r_open;
  assign w_lmr_ok    = !bus.Sa[2] && (bus.Sa[6:4] == 3'd2 || bus.Sa[6:4] == 3'd3) && !w_any_open;
  assign w_pipe_vld  = r_cl3 ? r_s1_vld : r_s0_vld;
  assign w_pipe_dat  = r_cl3 ? r_s1_dat : r_s0_dat;

  // Burst sequencing and command decode: a terminating command in this cycle overrides the running burst word
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_err       = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_waddr     = w_cont_addr;
    w_raddr     = w_cont_addr;
    w_flush     = 1'b0;
    w_start     = 1'b0;
    if (r_state != B_IDLE) begin
      w_we    = (r_state == B_WRITE);
      w_re    = (r_state == B_READ);
      w_k_nxt = r_k + 3'd1;
      if (w_last) w_state_nxt = B_IDLE;
    end
    case (w_cmd)
      C_ACT: w_err = w_bank_open;
      C_PRE: begin
        if (bus.Sa[10] || bus.Ba == r_bank) begin
          w_we        = 1'b0;
          w_re        = 1'b0;
          w_state_nxt = B_IDLE;
        end
      end
      C_REF: w_err = w_any_open;
      C_LMR: w_err = !w_lmr_ok;
      C_BST: begin
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_state_nxt = B_IDLE;
      end
      C_WR, C_RD: begin
        if (!w_bank_open || !r_mode_ok) begin
          w_err = 1'b1;
        end else begin
          w_start = 1'b1;
          w_k_nxt = 3'd1;
          w_waddr = w_cmd_addr;
          w_raddr = w_cmd_addr;
          w_we    = (w_cmd == C_WR);
          w_re    = (w_cmd == C_RD);
          w_flush = (w_cmd == C_WR);
          if (w_bl_m1 == 3'd0) w_state_nxt = B_IDLE;
          else                 w_state_nxt = (w_cmd == C_WR) ? B_WRITE : B_READ;
        end
      end
      default: ;
    endcase
  end

  // Burst state register: captures bank/row/column at burst start, steps word counter on Cke-high cycles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= B_IDLE;
      r_k     <= '0;
      r_bank  <= '0;
      r_brow  <= '0;
      r_col   <= '0;
    end else if (bus.Cke) begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_start) begin
        r_bank <= bus.Ba;
        r_brow <= r_row[bus.Ba];
        r_col  <= bus.Sa[COLW-1:0];
      end
    end
  end

  // Bank open flags, mode register, refresh counter and the registered error pulse
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_open    <= '0;
      r_bl_log  <= '0;
      r_cl3     <= 1'b0;
      r_mode_ok <= 1'b0;
      r_ref_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= bus.Cke && w_err;
      if (bus.Cke) begin
        case (w_cmd)
          C_ACT: r_open[bus.Ba] <= 1'b1;
          C_PRE: begin
            if (bus.Sa[10]) r_open <= '0;
            else            r_open[bus.Ba] <= 1'b0;
          end
          C_REF: r_ref_cnt <= r_ref_cnt + 16'd1;
          C_LMR: begin
            if (w_lmr_ok) begin
              r_bl_log  <= bus.Sa[1:0];
              r_cl3     <= bus.Sa[4];
              r_mode_ok <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Open-row latch per bank; only meaningful while that bank is open
  always_ff @(posedge Clk) begin
    if (bus.Cke && w_cmd == C_ACT) r_row[bus.Ba] <= bus.Sa;
  end

  // Backing RAM: byte-masked write, registered read with write-first forwarding on address match
  always_ff @(posedge Clk) begin
    if (bus.Cke) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (w_we && !bus.Dqm[i]) r_mem[w_waddr][i*8 +: 8] <= bus.Dq_in[i*8 +: 8];
        if (w_re) begin
          if (w_we && w_waddr == w_raddr && !bus.Dqm[i]) r_s0_dat[i*8 +: 8] <= bus.Dq_in[i*8 +: 8];
          else                                           r_s0_dat[i*8 +: 8] <= r_mem[w_raddr][i*8 +: 8];
        end
      end
    end
  end

  // Read pipeline: RAM stage, one extra stage for CL3, then the output register; a WRITE drops in-flight words
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s0_vld <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_dat <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
    end else if (bus.Cke) begin
      r_s0_vld <= w_re;
      if (w_flush) begin
        r_s1_vld <= 1'b0;
        r_dq_oe  <= 1'b0;
      end else begin
        r_s1_vld <= r_s0_vld;
        r_s1_dat <= r_s0_dat;
        r_dq_oe  <= w_pipe_vld;
        if (w_pipe_vld) r_dq_out <= w_pipe_dat;
      end
    end
  end

  assign bus.Dq_out  = r_dq_out;
  assign bus.Dq_oe   = r_dq_oe;
  assign bus.Mode_ok = r_mode_ok;
  assign bus.Err     = r_err;
  assign bus.Ref_cnt = r_ref_cnt;
endmodule

// File: tb/tb_sdram_device_emu.sv
// Directed bench for sdram_device_emu: mode load, bursts with wrap and byte mask, error pulses, PRE/WRITE truncation, Cke stall.
// Latency: commands are driven after a falling edge and sampled on the next rising edge; outputs checked on falling edges.
// Backpressure: exercised through Cke only.
module tb_sdram_device_emu;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sdram_device_emu_if #(.DSIZE(16), .ASIZE(13), .BSIZE(2)) bus ();

  sdram_device_emu #(.DSIZE(16), .ASIZE(13), .BSIZE(2), .COLW(9), .MEM_AW(12)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] sa,
                         input logic [15:0] dq, input logic [1:0] dqm);
    {bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n} = c;
    bus.Ba    = ba;
    bus.Sa    = sa;
    bus.Dq_in = dq;
    bus.Dqm   = dqm;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One command cycle; returns on the falling edge after the sampling edge
  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] sa,
                       input logic [15:0] dq);
    set_cmd(c, ba, sa, dq, 2'b00);
    tick(1);
    set_cmd(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
  endtask

  task automatic wdata(input logic [15:0] dq, input logic [1:0] dqm);
    bus.Dq_in = dq;
    bus.Dqm   = dqm;
    tick(1);
    bus.Dq_in = '0;
    bus.Dqm   = '0;
  endtask

  task automatic write_burst(input logic [12:0] col, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3, input logic [1:0] m1);
    issue(C_WR, 2'd1, col, d0);
    wdata(d1, m1);
    wdata(d2, 2'b00);
    wdata(d3, 2'b00);
  endtask

  // BL4/CL3 read in bank 1: idle at T+2, words at T+3..T+6, idle at T+7
  task automatic read_check(input string tag, input logic [12:0] col, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] exp [4];
    exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
    issue(C_RD, 2'd1, col, 16'd0);
    tick(1);
    check_val({tag, "_oe_early"}, 32'(bus.Dq_oe), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_val($sformatf("%s_oe%0d", tag, k), 32'(bus.Dq_oe), 32'd1);
      check_val($sformatf("%s_w%0d", tag, k), 32'(bus.Dq_out), 32'(exp[k]));
    end
    tick(1);
    check_val({tag, "_oe_end"}, 32'(bus.Dq_oe), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    bus.Cke = 1'b1;
    set_cmd(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    tick(3);
    check_val("rst_oe",      32'(bus.Dq_oe),   32'd0);
    check_val("rst_dq",      32'(bus.Dq_out),  32'd0);
    check_val("rst_mode_ok", 32'(bus.Mode_ok), 32'd0);
    check_val("rst_err",     32'(bus.Err),     32'd0);
    check_val("rst_ref",     32'(bus.Ref_cnt), 32'd0);
    rst = 1'b0;
    tick(1);

    issue(C_LMR, 2'd0, 13'h032, 16'd0);
    check_val("lmr_mode_ok", 32'(bus.Mode_ok), 32'd1);
    check_val("lmr_err",     32'(bus.Err),     32'd0);
    issue(C_REF, 2'd0, 13'd0, 16'd0);
    check_val("ref_cnt1",    32'(bus.Ref_cnt), 32'd1);
    check_val("ref_err",     32'(bus.Err),     32'd0);
    issue(C_ACT, 2'd1, 13'd5, 16'd0);
    check_val("act_err",     32'(bus.Err),     32'd0);

    write_burst(13'd8, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 2'b00);
    read_check("rd_c8", 13'd8, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);

    write_burst(13'd6, 16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3, 2'b00);
    read_check("rd_wrap", 13'd4, 16'h00B2, 16'h00B3, 16'h00B0, 16'h00B1);

    write_burst(13'd12, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00);
    write_burst(13'd12, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 2'b10);
    read_check("rd_dqm", 13'd12, 16'h1234, 16'hFF34, 16'h1234, 16'h1234);

    issue(C_RD, 2'd2, 13'd8, 16'd0);
    check_val("err_rd_closed", 32'(bus.Err), 32'd1);
    tick(1);
    check_val("err_pulse_end", 32'(bus.Err), 32'd0);
    tick(1);
    check_val("err_rd_no_oe",  32'(bus.Dq_oe),  32'd0);
    check_val("err_rd_dq_hold", 32'(bus.Dq_out), 32'h1234);

    issue(C_ACT, 2'd1, 13'd5, 16'd0);
    check_val("err_act_open", 32'(bus.Err), 32'd1);
    issue(C_LMR, 2'd0, 13'h070, 16'd0);
    check_val("err_lmr_bad",  32'(bus.Err), 32'd1);
    check_val("lmr_bad_mode_ok", 32'(bus.Mode_ok), 32'd1);
    issue(C_REF, 2'd0, 13'd0, 16'd0);
    check_val("err_ref_open", 32'(bus.Err),     32'd1);
    check_val("ref_cnt2",     32'(bus.Ref_cnt), 32'd2);
    read_check("rd_after_err", 13'd8, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);

    // WRITE two cycles after a READ: in-flight words never appear
    issue(C_RD, 2'd1, 13'd8, 16'd0);
    tick(1);
    issue(C_WR, 2'd1, 13'd8, 16'h00A0);
    check_val("wr_flush_oe0", 32'(bus.Dq_oe), 32'd0);
    wdata(16'h00A1, 2'b00);
    check_val("wr_flush_oe1", 32'(bus.Dq_oe), 32'd0);
    wdata(16'h00A2, 2'b00);
    wdata(16'h00A3, 2'b00);
    check_val("wr_flush_oe3", 32'(bus.Dq_oe), 32'd0);

    // PRE one cycle after READ: only word0 emerges
    issue(C_RD, 2'd1, 13'd8, 16'd0);
    issue(C_PRE, 2'd1, 13'd0, 16'd0);
    tick(1);
    check_val("pre_w0_oe", 32'(bus.Dq_oe),  32'd1);
    check_val("pre_w0",    32'(bus.Dq_out), 32'h00A0);
    tick(1);
    check_val("pre_w1_oe", 32'(bus.Dq_oe),  32'd0);
    check_val("pre_hold",  32'(bus.Dq_out), 32'h00A0);
    tick(1);
    check_val("pre_w2_oe", 32'(bus.Dq_oe),  32'd0);
    issue(C_RD, 2'd1, 13'd8, 16'd0);
    check_val("err_rd_after_pre", 32'(bus.Err), 32'd1);

    // Cke low for two edges in the middle of a read burst
    issue(C_ACT, 2'd1, 13'd5, 16'd0);
    issue(C_RD, 2'd1, 13'd4, 16'd0);
    tick(2);
    check_val("cke_w0_oe", 32'(bus.Dq_oe),  32'd1);
    check_val("cke_w0",    32'(bus.Dq_out), 32'h00B2);
    bus.Cke = 1'b0;
    tick(1);
    check_val("cke_hold1", 32'(bus.Dq_out), 32'h00B2);
    check_val("cke_hold1_oe", 32'(bus.Dq_oe), 32'd1);
    tick(1);
    check_val("cke_hold2", 32'(bus.Dq_out), 32'h00B2);
    bus.Cke = 1'b1;
    tick(1);
    check_val("cke_w1", 32'(bus.Dq_out), 32'h00B3);
    tick(1);
    check_val("cke_w2", 32'(bus.Dq_out), 32'h00B0);
    tick(1);
    check_val("cke_w3", 32'(bus.Dq_out), 32'h00B1);
    check_val("cke_w3_oe", 32'(bus.Dq_oe), 32'd1);
    tick(1);
    check_val("cke_end_oe", 32'(bus.Dq_oe), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
